kws_sample_bridge: RTL and testbench
====================================

// Module: kws_sample_bridge
// PURPOSE
//  Pad-side audio ingest bridge for the KWS accelerator. Synchronises the async
//  pad sample strobe and tags each sample with a channel. Buffers samples in a
//  parametrised FWFT FIFO and presents them on a valid/ready stream.
//  Sits between the io_in pads and the cnn_kws_accel sample input in user_project_wrapper.
// PARAMETERS
//  SAMPLE_W     16  sample width in bits (1..32)
//  NUM_CH       1   interleaved channel count (1..4); CH_W = max(1,$clog2(NUM_CH))
//  FIFO_DEPTH   16  FIFO entries, power of two, >=2
//  SYNC_STAGES  2   synchroniser flops on pad inputs (>=2)
// PORTS
//  wb_clk_i     in   1            single clock, all logic rising edge
//  wb_rst_i     in   1            synchronous active-high reset
//  pad_sample   in   SAMPLE_W     sample bus from pads, async, stable around strobe
//  pad_ch       in   CH_W         channel tag from pads, async, stable with pad_sample
//  pad_valid    in   1            async strobe, each rising edge = one sample
//  enable       in   1            1: accept samples; 0: ignore strobes, keep draining
//  m_valid      out  1            FIFO head valid
//  m_ready      in   1            downstream accept
//  m_data       out  SAMPLE_W     head sample
//  m_ch         out  CH_W         head channel tag
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow     out  1            sticky: a sample was dropped
//  drop_cnt     out  8            saturating count of dropped samples
//  clear_ovf    in   1            1-cycle pulse, clears overflow and drop_cnt
// BEHAVIOUR
//  Reset (wb_rst_i=1 at edge): sync chains, edge reg, FIFO ptrs cleared.
//   m_valid=0, m_data=0, m_ch=0, fifo_level=0, overflow=0, drop_cnt=0.
//   Reset mid-operation discards all buffered samples; no partial state survives.
//  Sync: pad_valid, pad_sample, pad_ch each pass through SYNC_STAGES flops in parallel.
//   Data and strobe stay aligned. evt = sync_valid & ~sync_valid_d.
//  Push: at edge where evt=1 and enable=1.
//   Not full, or full with a same-cycle pop: write {sync_ch, sync_sample} at wr_ptr.
//   Full with no pop: sample dropped; overflow<=1; drop_cnt<=min(drop_cnt+1,255).
//   evt with enable=0: ignored silently; no drop accounting.
//  Channel tag: pad_ch values >= NUM_CH are stored as-is, with no checking (NUM_CH=1: tag ignored, m_ch=0).
//  Pop: m_valid&&m_ready at edge -> rd_ptr advances.
//   m_data/m_ch always show the current head (FWFT).
//   m_data/m_ch hold their last value when empty.
//  Stream rule: once m_valid=1, m_data/m_ch remain stable until popped.
//  Pointers wrap modulo FIFO_DEPTH with an extra MSB for full/empty detection.
//  fifo_level = wr_ptr - rd_ptr. Push+pop in the same cycle leaves level unchanged.
//  Latency: FIFO empty, pad_valid first sampled high at edge 0.
//   Push occurs at edge SYNC_STAGES; m_valid=1 after that edge (SYNC_STAGES+1 edges).
//  Strobe rate: strobes must be spaced >= SYNC_STAGES+1 clocks; faster edges may merge.
//  clear_ovf: clears overflow and drop_cnt next edge.
//   A drop in the same cycle wins: overflow=1, drop_cnt=1.
//  No combinational path from m_ready to m_valid/m_data.
// TESTING
//  T1 reset: drive pad activity during wb_rst_i=1.
//   -> all outputs 0 for every reset cycle and the first cycle after release.
//  T2 latency: SYNC_STAGES=2, empty FIFO, pad_sample=16'hA5C3, pad_valid rise before edge 0.
//   -> m_valid=1 after edge 2, m_data=16'hA5C3, fifo_level=1.
//  T3 fill/overflow: DEPTH=16, m_ready=0, 18 strobes.
//   -> fifo_level=16, overflow=1, drop_cnt=2; drain yields first 16 in order.
//  T4 full+simultaneous: FIFO full, m_ready=1 on the push cycle.
//   -> no drop, level stays 16, popped head is oldest.
//  T5 clear race: clear_ovf on the same cycle as a drop.
//   -> overflow=1, drop_cnt=1; later clear alone -> 0,0.
//  T6 channels: NUM_CH=4, pad_ch 0..3 interleaved, random m_ready backpressure.
//   -> m_ch sequence 0,1,2,3 matches input.
//   -> m_data stable while m_valid&&!m_ready.
//   -> enable=0 strobes are absent from output with drop_cnt unchanged.
//   -> wb_rst_i mid-stream empties the FIFO (m_valid=0 next cycle).

Source files
------------

// File: rtl/kws_sample_bridge.sv
// Purpose: pad-side audio ingest. Synchronises the async pad strobe/data, tags samples with a channel and buffers them in an FWFT FIFO.
// Latency: a pad strobe first sampled at edge 0 is pushed at edge SYNC_STAGES, so m_valid rises after SYNC_STAGES+1 edges.
// Backpressure: m_ready stalls the FWFT head; a strobe into a full FIFO with no same-cycle pop is dropped and counted.
module kws_sample_bridge #(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_CH      = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [SAMPLE_W-1:0] pad_sample,
    input  logic [CH_W-1:0]     pad_ch,
    input  logic                pad_valid,
    input  logic                enable,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_data,
    output logic [CH_W-1:0]     m_ch,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow,
    output logic [7:0]          drop_cnt,
    input  logic                clear_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CH_W + SAMPLE_W;

    // Synchroniser chains: strobe, data and tag travel through identical
    // depths so the data seen at the detected edge belongs to that strobe.
    logic [SYNC_STAGES-1:0] sync_valid_q;
    logic [SAMPLE_W-1:0]    sync_sample_q [SYNC_STAGES];
    logic [CH_W-1:0]        sync_ch_q     [SYNC_STAGES];
    logic                   valid_d_q;

    // With a single channel the tag pins carry no meaning, so force it to 0.
    logic [CH_W-1:0] pad_ch_eff;
    assign pad_ch_eff = (NUM_CH == 1) ? '0 : pad_ch;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [EW-1:0]   hold_q;
    logic            overflow_q;
    logic [7:0]      drop_cnt_q;

    logic            evt;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [EW-1:0]   head;
    logic [EW-1:0]   shown;

    // Pad synchronisers plus the delayed strobe used for rising-edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_valid_q <= '0;
            valid_d_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_sample_q[i] <= '0;
                sync_ch_q[i]     <= '0;
            end
        end else begin
            sync_valid_q     <= {sync_valid_q[SYNC_STAGES-2:0], pad_valid};
            valid_d_q        <= sync_valid_q[SYNC_STAGES-1];
            sync_sample_q[0] <= pad_sample;
            sync_ch_q[0]     <= pad_ch_eff;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_sample_q[i] <= sync_sample_q[i-1];
                sync_ch_q[i]     <= sync_ch_q[i-1];
            end
        end
    end

    // Push/pop/drop decisions; a pop frees the slot the same-cycle push reuses.
    always_comb begin
        evt   = sync_valid_q[SYNC_STAGES-1] & ~valid_d_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = m_valid & m_ready;
        push  = ~wb_rst_i & evt & enable & (~full | pop);
        drop  = ~wb_rst_i & evt & enable & full & ~pop;
        head  = mem[rd_ptr_q[AW-1:0]];
    end

    // Storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {sync_ch_q[SYNC_STAGES-1], sync_sample_q[SYNC_STAGES-1]};
        end
    end

    // Pointers and the last popped entry, which is shown while the FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= head;
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_ovf) begin
                drop_cnt_q <= 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (clear_ovf) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Outputs depend only on state, so m_ready never reaches m_valid/m_data combinationally.
    always_comb begin
        shown      = empty ? hold_q : head;
        m_valid    = ~empty;
        m_data     = shown[SAMPLE_W-1:0];
        m_ch       = shown[EW-1:SAMPLE_W];
        fifo_level = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule

// File: tb/tb_kws_sample_bridge.sv
// Bench for kws_sample_bridge: directed pad strobes with a scoreboard queue of expected
// {ch,data}; a negedge monitor pops and compares on every accepted beat and checks
// head stability under backpressure.
module tb_kws_sample_bridge;

    localparam int SW    = 16;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int SS    = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] pad_sample;
    logic [1:0]  pad_ch;
    logic        pad_valid;
    logic        enable;
    logic        rdy_cmd;
    logic        bp_on;
    logic        bp_rdy;
    logic        m_ready;
    logic        clear_ovf;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_ch;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    assign m_ready = bp_on ? bp_rdy : rdy_cmd;

    kws_sample_bridge #(
        .SAMPLE_W   (SW),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SS)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .pad_sample(pad_sample),
        .pad_ch    (pad_ch),
        .pad_valid (pad_valid),
        .enable    (enable),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe, held high two clocks then low two clocks.
    task automatic send(input logic [15:0] d, input logic [1:0] c, input logic en);
        enable     = en;
        pad_sample = d;
        pad_ch     = c;
        pad_valid  = 1'b1;
        tick();
        tick();
        pad_valid = 1'b0;
        tick();
        tick();
        enable = 1'b1;
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 300 && (fifo_level != 0 || m_valid); i++) begin
            tick();
        end
        chk(nm, 32'(fifo_level), 32'd0);
    endtask

    // Random backpressure source.
    initial begin
        bp_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bp_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor.
    logic        prev_stall = 1'b0;
    logic [17:0] prev_head  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid) begin
                chk("head_stable", 32'({m_ch, m_data}), 32'(prev_head));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("pop_data", 32'({m_ch, m_data}), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_head  = {m_ch, m_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        pad_sample = '0;
        pad_ch     = '0;
        pad_valid  = 1'b0;
        enable     = 1'b1;
        rdy_cmd    = 1'b0;
        bp_on      = 1'b0;
        clear_ovf  = 1'b0;

        // T1: pad activity during reset, outputs must stay zero.
        for (int i = 0; i < 4; i++) begin
            pad_valid  = ~pad_valid;
            pad_sample = 16'($urandom);
            pad_ch     = 2'($urandom_range(0, 3));
            tick();
            chk("rst_ctrl", 32'({m_valid, fifo_level, overflow, drop_cnt}), 32'd0);
            chk("rst_data", 32'({m_ch, m_data}), 32'd0);
        end
        pad_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ctrl", 32'({m_valid, fifo_level, overflow, drop_cnt}), 32'd0);
        chk("post_rst_data", 32'({m_ch, m_data}), 32'd0);
        tick();

        // T2: latency of the first sample.
        pad_sample = 16'hA5C3;
        pad_ch     = 2'd0;
        pad_valid  = 1'b1;
        tick();
        chk("lat_edge0", 32'(m_valid), 32'd0);
        tick();
        chk("lat_edge1", 32'(m_valid), 32'd0);
        tick();
        chk("lat_edge2_valid", 32'(m_valid), 32'd1);
        chk("lat_edge2_data", 32'(m_data), 32'hA5C3);
        chk("lat_edge2_level", 32'(fifo_level), 32'd1);
        pad_valid = 1'b0;
        exp_q.push_back({2'd0, 16'hA5C3});
        rdy_cmd = 1'b1;
        wait_empty("t2_drain");
        chk("t2_hold_data", 32'(m_data), 32'hA5C3);
        rdy_cmd = 1'b0;

        // T3: 18 strobes into a 16-deep FIFO with no draining.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) exp_q.push_back({2'(i % 4), 16'h1000 + 16'(i)});
            send(16'h1000 + 16'(i), 2'(i % 4), 1'b1);
        end
        chk("t3_level", 32'(fifo_level), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);

        // T4: push into a full FIFO with a same-cycle pop.
        exp_q.push_back({2'd1, 16'h2000});
        pad_sample = 16'h2000;
        pad_ch     = 2'd1;
        pad_valid  = 1'b1;
        tick();
        tick();
        rdy_cmd = 1'b1;
        tick();
        rdy_cmd = 1'b0;
        chk("t4_level", 32'(fifo_level), 32'd16);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        pad_valid = 1'b0;
        tick();
        tick();

        // T5: clear coinciding with a drop, then clear alone.
        pad_sample = 16'h3000;
        pad_ch     = 2'd2;
        pad_valid  = 1'b1;
        tick();
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t5_race_ovf", 32'(overflow), 32'd1);
        chk("t5_race_cnt", 32'(drop_cnt), 32'd1);
        pad_valid = 1'b0;
        tick();
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t5_clear_ovf", 32'(overflow), 32'd0);
        chk("t5_clear_cnt", 32'(drop_cnt), 32'd0);

        // Drain the full FIFO under random backpressure.
        bp_on = 1'b1;
        wait_empty("t5_drain");

        // T6: interleaved channels, two strobes with enable low.
        for (int i = 0; i < 10; i++) begin
            logic en;
            en = (i != 4 && i != 7);
            if (en) exp_q.push_back({2'(i % 4), 16'hC000 + 16'(i * 16'h0111)});
            send(16'hC000 + 16'(i * 16'h0111), 2'(i % 4), en);
        end
        wait_empty("t6_drain");
        bp_on = 1'b0;
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);

        // Reset mid-stream discards buffered samples.
        rdy_cmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'hD000 + 16'(i), 2'(i), 1'b1);
        end
        chk("t6_pre_rst_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_level", 32'(fifo_level), 32'd0);
        chk("t6_rst_data", 32'({m_ch, m_data}), 32'd0);
        tick();

        // Recovery after the mid-stream reset.
        exp_q.push_back({2'd3, 16'hE5E5});
        send(16'hE5E5, 2'd3, 1'b1);
        rdy_cmd = 1'b1;
        wait_empty("recover_drain");
        rdy_cmd = 1'b0;
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
